// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: shared types, defaults and helpers for the clock period meter
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } state_t;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1024;

    // Increment that sticks at max instead of wrapping; callers narrow the result
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v == max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer with registered-delay edge detection
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_d;

    // Shift the async input through the synchronizer chain and keep one cycle of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_d    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_d    <= r_sync[SYNC_STAGES-1];
        end
    end

    assign q    = r_sync[SYNC_STAGES-1];
    assign rise = q & ~r_d;
    assign fall = ~q & r_d;

endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of an async signal in clk cycles
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck,
    output logic [CNT_W-1:0] meas_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_sig_s;
    logic             w_rise;
    logic             w_fall;
    logic             w_high;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_hcnt_inc;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic [CNT_W-1:0] r_meas_count;
    logic             r_meas_valid;
    logic             r_stuck;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sig_in),
        .q    (w_sig_s),
        .rise (w_rise),
        .fall (w_fall)
    );

    // High time accrues only while the synchronized signal sits high; the falling cycle is already low
    assign w_high     = w_sig_s & ~w_fall;
    assign w_cnt_inc  = CNT_W'(sat_inc(32'(r_cnt), 32'(CNT_MAX)));
    assign w_hcnt_inc = CNT_W'(sat_inc(32'(r_hcnt), 32'(CNT_MAX)));

    // Measurement FSM: arm on first rise, report each rise-to-rise interval, flag a silent input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_hcnt       <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_count <= '0;
            r_meas_valid <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if (!en) begin
                r_state <= IDLE;
                r_stuck <= 1'b0;
                r_cnt   <= '0;
                r_hcnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt  <= w_rise ? CNT_ONE : '0;
                        r_hcnt <= w_rise ? CNT_ONE : '0;
                        if (w_rise) r_state <= MEASURE;
                    end
                    MEASURE: begin
                        if (w_rise) begin
                            r_period     <= r_cnt;
                            r_high_time  <= r_hcnt;
                            r_meas_valid <= 1'b1;
                            r_meas_count <= r_meas_count + CNT_ONE;
                            r_cnt        <= CNT_ONE;
                            r_hcnt       <= CNT_ONE;
                        end else if (r_cnt == CNT_TO) begin
                            r_state <= STUCK;
                            r_stuck <= 1'b1;
                        end else begin
                            r_cnt  <= w_cnt_inc;
                            r_hcnt <= w_high ? w_hcnt_inc : r_hcnt;
                        end
                    end
                    STUCK: begin
                        if (w_rise) begin
                            r_state <= MEASURE;
                            r_stuck <= 1'b0;
                            r_cnt   <= CNT_ONE;
                            r_hcnt  <= CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_stuck <= 1'b0;
                        r_cnt   <= '0;
                        r_hcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_meas_valid;
    assign stuck      = r_stuck;
    assign meas_count = r_meas_count;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed scoreboard bench for the clock period meter
module tb_clk_period_meter;

    localparam int CW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          sig_in = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          stuck;
    logic [CW-1:0] meas_count;

    typedef struct {
        int p;
        int h;
        int c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   last_p = 0;
    int   last_h = 0;
    logic last_v = 1'b0;

    always #5 clk = ~clk;

    clk_period_meter #(
        .CNT_W      (CW),
        .SYNC_STAGES(2),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .stuck     (stuck),
        .meas_count(meas_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clk cycle; outputs sampled 1 ns after the rising edge, valid pulses popped from the scoreboard
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (meas_valid) begin
            chk("back_to_back_valid", 32'(last_v), 32'd0);
            chk("unexpected_valid", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("period", 32'(period), 32'(e.p));
                chk("high_time", 32'(high_time), 32'(e.h));
                chk("meas_count", 32'(meas_count), 32'(e.c));
            end
        end
        last_v = meas_valid;
    endtask

    // Drive hi cycles high then lo low; ep/eh != 0 means this rise closes an interval with that result
    task automatic pulse(input int hi, input int lo, input int ep, input int eh);
        if (ep != 0) begin
            exp_cnt++;
            q.push_back('{ep, eh, exp_cnt});
            last_p = ep;
            last_h = eh;
        end
        sig_in = 1'b1;
        repeat (hi) tick();
        sig_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic drained(input string tag);
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_high", 32'(high_time), 32'd0);
        chk("rst_count", 32'(meas_count), 32'd0);
        chk("rst_valid", 32'(meas_valid), 32'd0);
        chk("rst_stuck", 32'(stuck), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        tick();

        // 50% duty, period 4
        pulse(2, 2, 0, 0);
        repeat (4) pulse(2, 2, 4, 2);
        drained("drain_p4");

        // period 8 at 50%, then 2 high / 6 low
        pulse(4, 4, 4, 2);
        pulse(4, 4, 8, 4);
        pulse(4, 4, 8, 4);
        pulse(2, 6, 8, 4);
        pulse(2, 6, 8, 2);
        pulse(2, 6, 8, 2);
        drained("drain_p8");

        // next rise lands exactly on cnt == TIMEOUT: rise wins
        pulse(2, TO - 2, 8, 2);
        pulse(2, 2, TO, 2);
        chk("timeout_edge_stuck", 32'(stuck), 32'd0);
        drained("drain_timeout_edge");

        // held low after a rise: stuck exactly TIMEOUT+1 cycles after the synchronized rise
        pulse(1, 0, 4, 2);
        repeat (65) tick();
        chk("stuck_early", 32'(stuck), 32'd0);
        tick();
        chk("stuck_set", 32'(stuck), 32'd1);
        repeat (20) tick();
        chk("stuck_hold", 32'(stuck), 32'd1);
        drained("drain_stuck");
        pulse(2, 2, 0, 0);
        chk("stuck_clear", 32'(stuck), 32'd0);
        pulse(1, 3, 4, 2);
        pulse(2, 2, 4, 1);
        drained("drain_glitch");

        // enable dropped mid-interval for 3 cycles
        pulse(2, 1, 4, 2);
        en = 1'b0;
        repeat (3) tick();
        chk("en_hold_period", 32'(period), 32'(last_p));
        chk("en_hold_high", 32'(high_time), 32'(last_h));
        chk("en_hold_count", 32'(meas_count), 32'(exp_cnt));
        chk("en_stuck", 32'(stuck), 32'd0);
        en = 1'b1;
        pulse(2, 2, 0, 0);
        pulse(2, 2, 4, 2);
        drained("drain_en");

        // async reset between clock edges mid-interval
        pulse(2, 1, 4, 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_period", 32'(period), 32'd0);
        chk("arst_high", 32'(high_time), 32'd0);
        chk("arst_count", 32'(meas_count), 32'd0);
        chk("arst_valid", 32'(meas_valid), 32'd0);
        chk("arst_stuck", 32'(stuck), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        last_v = 1'b0;
        pulse(2, 2, 0, 0);
        pulse(2, 2, 4, 2);
        drained("drain_arst");
        chk("arst_recount", 32'(meas_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
